// File: rtl/ysyx_22040088_pkg.sv
// Shared fetch-side constants and the queue entry layout.
// Imported by the prefetch queue and its FIFO.
package ysyx_22040088_pkg;

   localparam int XLEN    = 64;
   localparam int INST_W  = 32;
   localparam int ENTRY_W = XLEN + INST_W;

   localparam logic [XLEN-1:0]   RESET_PC    = 64'h8000_0000;
   localparam logic [INST_W-1:0] BUBBLE_INST = 32'h0;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/ifu_prefetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous circular buffer holding fetched {pc, inst}.
// Ports: push/push_data, pop, flush (clears pointers), head_valid/head_data, count.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 96
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     head_valid,
   output logic [W-1:0]             head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_en, pop_en;

   always_comb begin
      pop_en   = pop && (cnt_q != '0);
      // A push into a full buffer is fine when the head leaves this cycle.
      push_en  = push && ((cnt_q != CW'(DEPTH)) || pop_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
         cnt_d = cnt_q + CW'(push_en) - CW'(pop_en);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head_valid = (cnt_q != '0);
   assign head_data  = mem_q[rd_ptr_q];
   assign count      = cnt_q;

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues pipelined imem requests,
// queues responses with their PCs and hands them to ID via valid/ready.
// Ports: clk, rst (async high); imem_req_* / imem_resp_* to instruction memory;
// redirect/redirect_pc from ID; out_valid/out_ready/out_pc/out_inst toward ID.
module ifu_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [63:0] RESET_PC = ysyx_22040088_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_inst
);

   import ysyx_22040088_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUT) + 1;
   localparam int SW = ((CW > OW) ? CW : OW) + 1;

   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [63:0]   resp_pc_q, resp_pc_d;
   logic [63:0]   redir_pc;
   logic [OW-1:0] inflight_q, inflight_d;
   logic [OW-1:0] drop_q, drop_d;
   logic [CW-1:0] count;
   logic [SW-1:0] occupancy;
   logic          head_valid;
   fq_entry_t     head, push_entry;
   logic          req_fire, resp_drop, push, pop;

   always_comb begin
      redir_pc  = redirect_pc & ~64'h3;
      // Queue slots are reserved at issue, so a response can always land.
      occupancy = SW'(count) + SW'(inflight_q);
      imem_req_valid = !rst && !redirect
                    && (occupancy < SW'(DEPTH))
                    && (inflight_q < OW'(MAX_OUT));
      imem_req_addr  = fetch_pc_q;
      req_fire   = imem_req_valid && imem_req_ready;
      resp_drop  = imem_resp_valid && (redirect || (drop_q != '0));
      push       = imem_resp_valid && !resp_drop;
      out_valid  = !rst && head_valid;
      pop        = out_valid && out_ready && !redirect;
      push_entry = '{pc: resp_pc_q, inst: imem_resp_data};
      out_pc     = out_valid ? head.pc : '0;
      out_inst   = out_valid ? head.inst : BUBBLE_INST;

      inflight_d = inflight_q + OW'(req_fire) - OW'(imem_resp_valid);

      if (redirect) begin
         // Everything still outstanding is stale now, including what was
         // already marked for dropping: the new drop count is just what
         // remains in flight once this cycle's response is consumed.
         drop_d     = inflight_q - OW'(imem_resp_valid);
         fetch_pc_d = redir_pc;
         resp_pc_d  = redir_pc;
      end else begin
         drop_d     = drop_q - OW'(imem_resp_valid && (drop_q != '0));
         fetch_pc_d = fetch_pc_q + (req_fire ? 64'd4 : 64'd0);
         resp_pc_d  = resp_pc_q + (push ? 64'd4 : 64'd0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  (push_entry),
      .pop        (pop),
      .flush      (redirect),
      .head_valid (head_valid),
      .head_data  (head),
      .count      (count)
   );

   a_inflight_max: assert property (@(posedge clk) disable iff (rst)
      inflight_q <= OW'(MAX_OUT));
   a_occupancy: assert property (@(posedge clk) disable iff (rst)
      occupancy <= SW'(DEPTH));
   a_drop_le_inflight: assert property (@(posedge clk) disable iff (rst)
      drop_q <= inflight_q);
   a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
      imem_resp_valid |-> (inflight_q != '0));

endmodule
